// File: rtl/ahb_frame_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_frame_slave_if
//  Description : AHB-style single-transfer bus between an initiator and the
//                frame-buffer responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_frame_slave_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [7:0]  err_count;

    modport slave (
        input  hsel, htrans, haddr, hwrite, hwdata,
        output hrdata, hready, err_count
    );

    modport master (
        output hsel, htrans, haddr, hwrite, hwdata,
        input  hrdata, hready, err_count
    );
endinterface
`default_nettype wire

// File: rtl/ahb_frame_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_frame_slave
//  Description : Word-addressed frame buffer behind an AHB-style responder
//                with a fixed number of hready wait states per transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_frame_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ahb_frame_slave_if.slave   bus
);

    localparam int          c_IDX_W = $clog2(DEPTH);
    localparam logic [32:0] c_SPAN  = 33'(4 * DEPTH);
    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic [3:0]         r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_write;
    logic               r_valid;
    logic [31:0]        r_rdata;
    logic [7:0]         r_err;
    logic [31:0]        r_mem [DEPTH];

    logic [32:0]        w_off;
    logic               w_valid;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_accept;
    logic               w_commit;
    logic               w_load;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_rd_valid;
    logic [31:0]        w_load_data;
    logic               w_unused;

    // An address below BASE_ADDR wraps into bit 32, so one compare covers both bounds.
    assign w_off    = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
    assign w_valid  = (w_off < c_SPAN) && (bus.haddr[1:0] == 2'b00);
    assign w_idx    = w_off[c_IDX_W+1:2];
    assign w_accept = bus.hsel & bus.htrans[1] & r_ready;
    assign w_unused = bus.htrans[0];

    assign w_commit = (r_state == S_LAST) & r_write & r_valid & ~rst;

    // With no wait states LAST is entered straight from the address phase,
    // so the read index comes from the bus instead of the latched copy.
    always_comb begin
        w_load     = 1'b0;
        w_rd_idx   = r_idx;
        w_rd_valid = r_valid;
        if (WAIT_STATES == 0) begin
            w_load     = w_accept & ~bus.hwrite;
            w_rd_idx   = w_idx;
            w_rd_valid = w_valid;
        end else begin
            w_load     = (r_state == S_WAIT) && (r_cnt == 4'd0) && !r_write;
        end
    end

    always_comb begin
        w_load_data = 32'h0;
        if (w_rd_valid) begin
            if (w_commit && (r_idx == w_rd_idx))
                w_load_data = bus.hwdata;
            else
                w_load_data = r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit)
            r_mem[r_idx] <= bus.hwdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_valid <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_idx   <= w_idx;
                r_write <= bus.hwrite;
                r_valid <= w_valid;
                if (!w_valid && (r_err != 8'hFF))
                    r_err <= r_err + 8'd1;
                if (WAIT_STATES > 0) begin
                    r_state <= S_WAIT;
                    r_cnt   <= c_WAIT_INIT;
                    r_ready <= 1'b0;
                end else begin
                    r_state <= S_LAST;
                    r_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_LAST;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    S_LAST: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                endcase
            end
            if (w_load)
                r_rdata <= w_load_data;
        end
    end

    assign bus.hready    = r_ready;
    assign bus.hrdata    = r_rdata;
    assign bus.err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_frame_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_frame_slave
//  Description : Scoreboard bench for ahb_frame_slave with 0, 1 and 3 wait
//                states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_frame_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    ahb_frame_slave_if bus0();
    ahb_frame_slave_if bus1();
    ahb_frame_slave_if bus2();

    ahb_frame_slave #(.WAIT_STATES(0)) u_w0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
    ahb_frame_slave #(.WAIT_STATES(1)) u_w1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
    ahb_frame_slave #(.WAIT_STATES(3)) u_w3 (.clk(clk), .rst(rst2), .bus(bus2.slave));

    typedef struct {
        bit          chk_rd;
        logic [31:0] rdata;
        int          stalls;
        string       name;
    } item_t;

    item_t sbq[3][$];
    int    wcfg[3] = '{0, 1, 3};
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    function automatic logic get_ready(int d);
        case (d)
            0:       return bus0.hready;
            1:       return bus1.hready;
            default: return bus2.hready;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(int d);
        case (d)
            0:       return bus0.hrdata;
            1:       return bus1.hrdata;
            default: return bus2.hrdata;
        endcase
    endfunction

    task automatic drive(int d, logic sel, logic [1:0] tr, logic [31:0] a, logic wr);
        case (d)
            0:       begin bus0.hsel = sel; bus0.htrans = tr; bus0.haddr = a; bus0.hwrite = wr; end
            1:       begin bus1.hsel = sel; bus1.htrans = tr; bus1.haddr = a; bus1.hwrite = wr; end
            default: begin bus2.hsel = sel; bus2.htrans = tr; bus2.haddr = a; bus2.hwrite = wr; end
        endcase
    endtask

    task automatic set_wdata(int d, logic [31:0] v);
        case (d)
            0:       bus0.hwdata = v;
            1:       bus1.hwdata = v;
            default: bus2.hwdata = v;
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int d, string nm, bit chk, logic [31:0] rd, int st);
        item_t it;
        it.chk_rd = chk;
        it.rdata  = rd;
        it.stalls = st;
        it.name   = nm;
        sbq[d].push_back(it);
    endtask

    // Address phase in the current cycle, then hwdata held for all W+1 data cycles.
    task automatic xfer(int d, string nm, logic [31:0] a, logic wr,
                        logic [31:0] wd, logic [31:0] exp_rd);
        drive(d, 1'b1, 2'b10, a, wr);
        push(d, nm, !wr, exp_rd, wcfg[d]);
        cyc();
        drive(d, 1'b0, 2'b00, 32'h0, 1'b0);
        set_wdata(d, wd);
        repeat (wcfg[d] + 1) cyc();
    endtask

    task automatic monitor(int d);
        item_t it;
        int    st;
        bit    done;
        forever begin
            @(negedge clk);
            while (sbq[d].size() > 0) begin
                it   = sbq[d].pop_front();
                st   = 0;
                done = 1'b0;
                for (int c = 0; c < 64 && !done; c++) begin
                    @(negedge clk);
                    if (get_ready(d)) done = 1'b1;
                    else st++;
                end
                if (!done) begin
                    n_total++;
                    $display("FAIL %s: hready stuck low, got %0d stalls, expected %0d", it.name, st, it.stalls);
                end else begin
                    check($sformatf("%s stalls", it.name), 32'(st), 32'(it.stalls));
                    if (it.chk_rd)
                        check($sformatf("%s hrdata", it.name), get_rdata(d), it.rdata);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    function automatic bit all_empty();
        return (sbq[0].size() == 0) && (sbq[1].size() == 0) && (sbq[2].size() == 0);
    endfunction

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 2'b00, 32'h0, 1'b0);
            set_wdata(d, 32'h0);
        end
        repeat (3) cyc();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        @(negedge clk);
        check("reset hready w1", 32'(bus1.hready), 32'd1);
        check("reset hrdata w1", bus1.hrdata, 32'h0);
        check("reset err w1", 32'(bus1.err_count), 32'd0);
        check("reset hready w0", 32'(bus0.hready), 32'd1);
        check("reset hready w3", 32'(bus2.hready), 32'd1);
        cyc();

        // One wait state: write, one idle cycle, read back.
        xfer(1, "w1_wr10", 32'h10, 1'b1, 32'hCAFE_F00D, 32'h0);
        cyc();
        xfer(1, "w1_rd10", 32'h10, 1'b0, 32'h0, 32'hCAFE_F00D);

        // Idle bus inputs at a valid address must not start a transfer.
        drive(1, 1'b1, 2'b00, 32'h10, 1'b1);
        set_wdata(1, 32'hFFFF_FFFF);
        @(negedge clk);
        check("idle htrans00 hready", 32'(bus1.hready), 32'd1);
        cyc();
        drive(1, 1'b0, 2'b10, 32'h10, 1'b1);
        @(negedge clk);
        check("idle hsel0 hready a", 32'(bus1.hready), 32'd1);
        cyc();
        drive(1, 1'b0, 2'b00, 32'h0, 1'b0);
        @(negedge clk);
        check("idle hsel0 hready b", 32'(bus1.hready), 32'd1);
        check("idle err", 32'(bus1.err_count), 32'd0);
        cyc();
        xfer(1, "w1_rd10_after_idle", 32'h10, 1'b0, 32'h0, 32'hCAFE_F00D);

        // Out-of-range and misaligned transfers.
        xfer(1, "w1_wr0", 32'h0, 1'b1, 32'h1111_1111, 32'h0);
        xfer(1, "w1_rd_oob", 32'h1000, 1'b0, 32'h0, 32'h0);
        xfer(1, "w1_wr_mis", 32'h2, 1'b1, 32'hBAD0_BAD0, 32'h0);
        xfer(1, "w1_rd0", 32'h0, 1'b0, 32'h0, 32'h1111_1111);
        @(negedge clk);
        check("err after two invalid", 32'(bus1.err_count), 32'd2);
        cyc();

        // Reset during the wait cycle of a write drops the write.
        xfer(1, "w1_wr40", 32'h40, 1'b1, 32'h0000_0001, 32'h0);
        xfer(1, "w1_rd40", 32'h40, 1'b0, 32'h0, 32'h0000_0001);
        drive(1, 1'b1, 2'b10, 32'h40, 1'b1);
        push(1, "w1_rst_abort", 1'b1, 32'h0, 1);
        cyc();
        drive(1, 1'b0, 2'b00, 32'h0, 1'b0);
        set_wdata(1, 32'hDEAD_BEEF);
        rst1 = 1'b1;
        cyc();
        rst1 = 1'b0;
        @(negedge clk);
        check("err after reset", 32'(bus1.err_count), 32'd0);
        cyc();
        xfer(1, "w1_rd40_after_rst", 32'h40, 1'b0, 32'h0, 32'h0000_0001);

        // Saturation of the error counter.
        for (int i = 0; i < 254; i++)
            xfer(1, "w1_oob_sat", 32'h2000 + 32'(i * 4), 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        check("err at 254", 32'(bus1.err_count), 32'd254);
        cyc();
        for (int i = 0; i < 46; i++)
            xfer(1, "w1_oob_sat", 32'h3001, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("err saturated", 32'(bus1.err_count), 32'd255);
        cyc();

        // Three wait states.
        xfer(2, "w3_wr8", 32'h8, 1'b1, 32'h1234_5678, 32'h0);
        xfer(2, "w3_rd8", 32'h8, 1'b0, 32'h0, 32'h1234_5678);

        // Zero wait states: read pipelined behind a write to the same word.
        xfer(0, "w0_pre20", 32'h20, 1'b1, 32'h5555_5555, 32'h0);
        xfer(0, "w0_rd20_pre", 32'h20, 1'b0, 32'h0, 32'h5555_5555);
        drive(0, 1'b1, 2'b10, 32'h20, 1'b1);
        push(0, "w0_wr20", 1'b0, 32'h0, 0);
        cyc();
        set_wdata(0, 32'hA5A5_A5A5);
        drive(0, 1'b1, 2'b10, 32'h20, 1'b0);
        push(0, "w0_rd20_fwd", 1'b1, 32'hA5A5_A5A5, 0);
        cyc();
        drive(0, 1'b0, 2'b00, 32'h0, 1'b0);
        cyc();
        xfer(0, "w0_rd20_mem", 32'h20, 1'b0, 32'h0, 32'hA5A5_A5A5);

        for (int i = 0; i < 200; i++) begin
            if (all_empty()) break;
            cyc();
        end
        repeat (80) cyc();
        if (!all_empty()) begin
            n_total++;
            $display("FAIL drain: got %0d pending transfers, expected 0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
